data_mem_sized: RTL and testbench
=================================

DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words; power of two, 4..65536.
REQ-002 Parameter RD_LATENCY, default 1, cycles from request accept to response; legal range 1..4.
REQ-003 Reset is asynchronous and active-high; single clock domain.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 req_wr  in  1  1=store, 0=load.
REQ-009 req_size  in  2  mem_size_t: byte/half/word; 2'b11 reserved.
REQ-010 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_addr  in  32  byte address.
REQ-012 req_wr_data  in  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_rd_data  out  32  load result, extended; 0 for stores and errors.
REQ-015 rsp_err  out  1  request rejected: misaligned, out of range, or reserved size.

Function
REQ-016 Accept occurs on a rising edge where req_valid and req_ready are both 1; call it edge N.
REQ-017 FSM states: IDLE, WAIT, RESP; IDLE->WAIT on accept; WAIT->RESP when latency counter reaches 0; RESP->WAIT on a new accept, else RESP->IDLE.
REQ-018 req_ready is 1 in IDLE and RESP only; 0 in WAIT.
REQ-019 Latency counter loads RD_LATENCY-1 on accept and decrements each WAIT cycle.
REQ-020 rsp_valid is 1 for exactly the one cycle following edge N+RD_LATENCY; every accepted request yields exactly one response.
REQ-021 Store writes only the addressed byte lanes at edge N: byte lane addr[1:0]; half lanes addr[1]*2 and +1; word all four.
REQ-022 Load samples the addressed word at edge N, with read-after-earlier-store semantics; a later store cannot change a pending load result.
REQ-023 Load extraction: the selected byte or half shifts to bit 0, then zero- or sign-extends per req_unsigned; req_unsigned is ignored for word loads.
REQ-024 Errors:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_size=2'b11;
  - addr[31:2] >= DEPTH_WORDS.
REQ-025 On error: no array write, rsp_err=1, rsp_rd_data=0; the response timing is unchanged.
REQ-026 rsp_rd_data and rsp_err hold 0 whenever rsp_valid=0.
REQ-027 Request inputs are ignored while req_ready=0; the requester must hold req_valid; no request is dropped or duplicated.

Reset
REQ-028 rst forces IDLE, req_ready=1, rsp_valid=0, rsp_rd_data=0, rsp_err=0, latency counter=0.
REQ-029 rst mid-operation aborts any in-flight request with no response; a store accepted before rst remains committed.
REQ-030 Array contents are not cleared by rst.

Configuration
REQ-031 Macro DATA_MEM_SIZED_STATS_EN, when defined, adds outputs stat_loads, stat_stores, stat_errs, each 32 bits.
REQ-032 Each counter increments on the response cycle of its class: an error counts only in stat_errs, not as a load or store.
REQ-033 Counters saturate at 32'hFFFF_FFFF and reset to 0 on rst.
REQ-034 Without the macro, the stat ports and counter logic are absent; all other behaviour is identical.

Structure
REQ-035 mem_size_t (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10) is defined in riscv_32i_defs_pkg.
REQ-036 The lane-mask and load-extend helper functions are defined in riscv_32i_defs_pkg.
REQ-037 Sub-module data_mem_array holds the storage: DEPTH_WORDS x 32 bits, 4-bit byte write enable, synchronous read.

Verification
REQ-038 Scenario: store word 0xDEADBEEF @0x10, then load word @0x10 -> rd_data=0xDEADBEEF, err=0.
REQ-039 Scenario: store byte 0x80 @0x11, then load byte signed @0x11 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word @0x10 -> 0xDEAD80EF.
REQ-040 Scenario: load half @0x13 -> err=1, rd_data=0; store word @0x22 -> err=1, memory unchanged.
REQ-041 Scenario: DEPTH_WORDS=256, load word @0x400 -> err=1.
REQ-042 Scenario: RD_LATENCY=3, request accepted at edge N -> rsp_valid only in the cycle after edge N+3; req_ready=0 during WAIT; back-to-back accept during RESP is accepted.
REQ-043 Scenario: rst asserted during WAIT -> no rsp_valid; a store accepted before rst reads back its value; with DATA_MEM_SIZED_STATS_EN, counters read 0 after rst.

Source files
------------

// File: rtl/riscv_32i_defs_pkg.sv
// riscv_32i_defs_pkg: memory access size type, controller states and byte-lane helpers
package riscv_32i_defs_pkg;
   typedef enum logic [1:0] {MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10} mem_size_t;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_t;
   function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] off);
      return size == MEM_BYTE ? 4'b0001 << off :
             size == MEM_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
             size == MEM_WORD ? 4'b1111 : 4'b0000;
   endfunction
   // The selected byte/half is shifted down to bit 0 before extension.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_t size,
                                               input logic [1:0] off, input logic uns);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      return size == MEM_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
             size == MEM_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : word;
   endfunction
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: byte-writable word storage with a registered read port
module data_mem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH_WORDS];
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/data_mem_sized.sv
// data_mem_sized: sized load/store data memory with fixed read latency and error checking
// Optional DATA_MEM_SIZED_STATS_EN adds saturating load/store/error response counters.
module data_mem_sized
   import riscv_32i_defs_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wr_data,
   output logic        rsp_valid,
   output logic [31:0] rsp_rd_data,
   output logic        rsp_err
`ifdef DATA_MEM_SIZED_STATS_EN
   ,
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
   output logic [31:0] stat_errs
`endif
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);
   dm_state_t state, state_nx;
   logic [1:0] cnt, cnt_nx, p_off;
   mem_size_t size, p_size;
   logic accept, err_now, p_wr, p_err, p_uns;
   logic [31:0] rdata, wdata;
   assign size = mem_size_t'(req_size);
   assign req_ready = state != WAIT;
   assign accept = req_valid & req_ready;
   assign err_now = req_size == 2'b11 || (size == MEM_HALF && req_addr[0]) ||
                    (size == MEM_WORD && req_addr[1:0] != 2'b00) ||
                    {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
   // Replicating the store data puts it in every lane; the lane mask picks the right ones.
   assign wdata = size == MEM_BYTE ? {4{req_wr_data[7:0]}} :
                  size == MEM_HALF ? {2{req_wr_data[15:0]}} : req_wr_data;
   data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk  (clk),
      .we   (accept && req_wr && !err_now ? lane_mask(size, req_addr[1:0]) : 4'b0000),
      .re   (accept && !req_wr),
      .addr (req_addr[AW+1:2]),
      .wdata(wdata),
      .rdata(rdata)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= 2'd0;
         p_wr <= 1'b0;
         p_err <= 1'b0;
         p_uns <= 1'b0;
         p_size <= MEM_BYTE;
         p_off <= 2'd0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         if (accept) begin
            p_wr <= req_wr;
            p_err <= err_now;
            p_uns <= req_unsigned;
            p_size <= size;
            p_off <= req_addr[1:0];
         end
      end
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      if (accept) begin
         state_nx = WAIT;
         cnt_nx = LAT_M1;
      end else if (state == WAIT) begin
         state_nx = cnt == 2'd0 ? RESP : WAIT;
         cnt_nx = cnt == 2'd0 ? cnt : cnt - 2'd1;
      end else
         state_nx = IDLE;
   end
   assign rsp_valid = state == RESP;
   assign rsp_err = rsp_valid & p_err;
   assign rsp_rd_data = rsp_valid && !p_err && !p_wr ? load_extend(rdata, p_size, p_off, p_uns) : 32'd0;
`ifdef DATA_MEM_SIZED_STATS_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         stat_loads <= 32'd0;
         stat_stores <= 32'd0;
         stat_errs <= 32'd0;
      end else if (rsp_valid) begin
         if (p_err && stat_errs != '1) stat_errs <= stat_errs + 32'd1;
         if (!p_err && p_wr && stat_stores != '1) stat_stores <= stat_stores + 32'd1;
         if (!p_err && !p_wr && stat_loads != '1) stat_loads <= stat_loads + 32'd1;
      end
`endif
endmodule

// File: tb/tb_data_mem_sized.sv
// tb_data_mem_sized: directed and randomized checks of data_mem_sized against a byte-array model
module tb_data_mem_sized;
   localparam int DEPTH = 256;
   localparam int LAT = 3;
   typedef struct packed {
      logic wr; logic [1:0] sz; logic u; logic [31:0] a; logic [31:0] d; logic [31:0] rd; logic er;
   } dir_t;
   localparam dir_t TBL [24] = '{
      '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b1, 2'd0, 1'b0, 32'h11,  32'h80,       32'h0,        1'b0},
      '{1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0},
      '{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'h00000080, 1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0},
      '{1'b0, 2'd2, 1'b1, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0},
      '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0},
      '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0},
      '{1'b0, 2'd1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1},
      '{1'b1, 2'd2, 1'b0, 32'h20,  32'h12345678, 32'h0,        1'b0},
      '{1'b1, 2'd2, 1'b0, 32'h22,  32'hFFFFFFFF, 32'h0,        1'b1},
      '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h12345678, 1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1},
      '{1'b1, 2'd2, 1'b0, 32'h3FC, 32'hA5A55A5A, 32'h0,        1'b0},
      '{1'b0, 2'd1, 1'b1, 32'h3FE, 32'h0,        32'h0000A5A5, 1'b0},
      '{1'b0, 2'd1, 1'b0, 32'h3FE, 32'h0,        32'hFFFFA5A5, 1'b0},
      '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1},
      '{1'b1, 2'd3, 1'b0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1},
      '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0},
      '{1'b1, 2'd1, 1'b0, 32'h12,  32'h0000CAFE, 32'h0,        1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hCAFE80EF, 1'b0},
      '{1'b1, 2'd0, 1'b0, 32'h13,  32'h000001FF, 32'h0,        1'b0},
      '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hFFFE80EF, 1'b0}
   };
   logic clk = 0, rst = 1, req_valid = 0, req_wr = 0, req_unsigned = 0;
   logic [1:0] req_size = 0;
   logic [31:0] req_addr = 0, req_wr_data = 0;
   logic req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rd_data;
   int n_cmp = 0, n_fail = 0;
   int ref_ld = 0, ref_st = 0, ref_er = 0;
   logic [7:0] ref_mem [DEPTH*4];
`ifdef DATA_MEM_SIZED_STATS_EN
   logic [31:0] stat_loads, stat_stores, stat_errs;
`endif
   data_mem_sized #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wr_data(req_wr_data),
      .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err)
`ifdef DATA_MEM_SIZED_STATS_EN
      , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
   );
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int nbytes(logic [1:0] sz);
      return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
   endfunction
   function automatic logic ref_err(logic [1:0] sz, logic [31:0] a);
      return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a / 4 >= DEPTH;
   endfunction
   function automatic logic [31:0] ref_load(logic [1:0] sz, logic u, logic [31:0] a);
      logic [31:0] v = 0;
      for (int i = 0; i < nbytes(sz); i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
      if (!u && sz == 2'd0 && v[7]) v = v | 32'hFFFFFF00;
      if (!u && sz == 2'd1 && v[15]) v = v | 32'hFFFF0000;
      return v;
   endfunction
   function automatic void ref_store(logic [1:0] sz, logic [31:0] a, logic [31:0] d);
      for (int i = 0; i < nbytes(sz); i++) ref_mem[a + i] = d[8*i +: 8];
   endfunction

   // One request; observes response timing, data, ready during wait, and idle-output leakage.
   task automatic txn(input logic wr, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er,
                      output int k_valid, output int n_valid, output int n_bad);
      int g = 0;
      @(negedge clk);
      req_valid = 1; req_wr = wr; req_size = sz; req_unsigned = u; req_addr = a; req_wr_data = d;
      while (!req_ready && g < 20) begin @(negedge clk); g++; end
      @(posedge clk);
      #1 req_valid = 0; req_wr = 1'($urandom); req_addr = $urandom; req_wr_data = $urandom;
      if (ref_err(sz, a)) ref_er++; else if (wr) begin ref_st++; ref_store(sz, a, d); end else ref_ld++;
      rd = 0; er = 0; k_valid = -1; n_valid = 0; n_bad = g >= 20 ? 1 : 0;
      for (int s = 0; s <= LAT + 1; s++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin n_valid++; k_valid = s; rd = rsp_rd_data; er = rsp_err; end
         else if (rsp_rd_data !== 32'd0 || rsp_err !== 1'b0) n_bad++;
         if (req_ready !== (s >= LAT)) n_bad++;
      end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
      n_cmp++; if (rsp_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data got=%h want=0", rsp_rd_data); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", rsp_err); end
`ifdef DATA_MEM_SIZED_STATS_EN
      n_cmp++; if ({stat_loads, stat_stores, stat_errs} !== 96'd0) begin n_fail++;
         $display("FAIL reset_stats got=%0d/%0d/%0d want=0/0/0", stat_loads, stat_stores, stat_errs); end
`endif
      rst = 0;
   endtask

   task automatic test_fill;
      logic [31:0] rd; logic er; int k, n, b;
      for (int w = 0; w < DEPTH; w++) begin
         txn(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, rd, er, k, n, b);
         n_cmp++; if (rd !== 0 || er !== 0 || k !== LAT || n !== 1 || b !== 0) begin n_fail++;
            $display("FAIL fill_w%0d rd=%h err=%b lat=%0d cnt=%0d bad=%0d want rd=0 err=0 lat=%0d cnt=1 bad=0", w, rd, er, k, n, b, LAT); end
      end
   endtask

   task automatic test_directed;
      logic [31:0] rd; logic er; int k, n, b;
      foreach (TBL[i]) begin
         txn(TBL[i].wr, TBL[i].sz, TBL[i].u, TBL[i].a, TBL[i].d, rd, er, k, n, b);
         n_cmp++; if (rd !== TBL[i].rd || er !== TBL[i].er || k !== LAT || n !== 1 || b !== 0) begin n_fail++;
            $display("FAIL directed_%0d rd=%h err=%b lat=%0d cnt=%0d bad=%0d want rd=%h err=%b lat=%0d cnt=1 bad=0",
                     i, rd, er, k, n, b, TBL[i].rd, TBL[i].er, LAT); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d = $urandom, a = 32'h100;
      int bad = 0, k2 = -1;
      logic [31:0] rd1 = 32'hX, rd2 = 0;
      @(negedge clk);
      req_valid = 1; req_wr = 1; req_size = 2'd2; req_unsigned = 0; req_addr = a; req_wr_data = d;
      @(posedge clk);
      #1 req_wr = 0; req_wr_data = ~d;
      for (int s = 0; s <= LAT; s++) begin
         @(negedge clk);
         if (s < LAT && (rsp_valid !== 1'b0 || req_ready !== 1'b0)) bad++;
         if (s == LAT) begin
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || req_ready !== 1'b1) bad++;
            rd1 = rsp_rd_data;
         end
      end
      @(posedge clk);
      #1 req_valid = 0;
      for (int s = 0; s <= LAT + 1; s++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin k2 = s; rd2 = rsp_rd_data; end
      end
      ref_store(2'd2, a, d); ref_st++; ref_ld++;
      n_cmp++; if (bad != 0 || rd1 !== 32'd0) begin n_fail++;
         $display("FAIL b2b_first bad=%0d rd=%h want bad=0 rd=0", bad, rd1); end
      n_cmp++; if (k2 !== LAT || rd2 !== d) begin n_fail++;
         $display("FAIL b2b_second lat=%0d rd=%h want lat=%0d rd=%h", k2, rd2, LAT, d); end
   endtask

   task automatic test_random;
      logic [31:0] rd, a, d, exp; logic er, wr, u, ee; logic [1:0] sz; int k, n, b, r;
      for (int t = 0; t < 300; t++) begin
         r = $urandom_range(0, 9);
         sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
         a = r == 0 ? $urandom : $urandom_range(0, DEPTH * 4 - 1);
         if (r >= 4) a = a & ~32'(sz == 2'd2 ? 3 : sz == 2'd1 ? 1 : 0);
         wr = 1'($urandom); u = 1'($urandom); d = $urandom;
         ee = ref_err(sz, a);
         exp = ee || wr ? 32'd0 : ref_load(sz, u, a);
         txn(wr, sz, u, a, d, rd, er, k, n, b);
         n_cmp++; if (rd !== exp || er !== ee || k !== LAT || n !== 1 || b !== 0) begin n_fail++;
            $display("FAIL random_%0d wr=%b sz=%0d u=%b a=%h rd=%h err=%b lat=%0d cnt=%0d bad=%0d want rd=%h err=%b",
                     t, wr, sz, u, a, rd, er, k, n, b, exp, ee); end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d = $urandom, rd; logic er; int k, n, b, seen = 0;
      @(negedge clk);
      req_valid = 1; req_wr = 1; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h40; req_wr_data = d;
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
      rst = 0;
      ref_store(2'd2, 32'h40, d); ref_ld = 0; ref_st = 0; ref_er = 0;
      for (int s = 0; s <= LAT + 1; s++) begin @(negedge clk); if (rsp_valid !== 1'b0) seen++; end
      n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL reset_abort stray=%0d want 0", seen); end
`ifdef DATA_MEM_SIZED_STATS_EN
      n_cmp++; if ({stat_loads, stat_stores, stat_errs} !== 96'd0) begin n_fail++;
         $display("FAIL reset_mid_stats got=%0d/%0d/%0d want=0/0/0", stat_loads, stat_stores, stat_errs); end
`endif
      txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, k, n, b);
      n_cmp++; if (rd !== d || er !== 0 || k !== LAT || n !== 1) begin n_fail++;
         $display("FAIL reset_commit rd=%h err=%b lat=%0d want rd=%h err=0 lat=%0d", rd, er, k, d, LAT); end
   endtask

`ifdef DATA_MEM_SIZED_STATS_EN
   task automatic test_stats;
      n_cmp++; if (stat_loads !== 32'(ref_ld) || stat_stores !== 32'(ref_st) || stat_errs !== 32'(ref_er)) begin n_fail++;
         $display("FAIL stats got=%0d/%0d/%0d want=%0d/%0d/%0d", stat_loads, stat_stores, stat_errs, ref_ld, ref_st, ref_er); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_random();
`ifdef DATA_MEM_SIZED_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end
endmodule
